// File: rtl/state_trace_buffer.sv
// Timestamped trace recorder for an FSM state bus: circular buffer with change-only or
// every-cycle capture, overwrite-on-full, and a state-match trigger that freezes capture.
module state_trace_buffer #(
    parameter int STATE_W = 5,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic [STATE_W-1:0]        i_state_in,
    input  logic                      i_cap_en,
    input  logic                      i_mode,
    input  logic                      i_trig_en,
    input  logic [STATE_W-1:0]        i_trig_state,
    input  logic                      i_rd_ready,
    output logic                      o_rd_valid,
    output logic [TS_W+STATE_W-1:0]   o_rd_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_overflow,
    output logic                      o_triggered,
    output logic                      o_frozen
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = TS_W + STATE_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_FROZEN
    } trig_fsm_t;

    logic [DW-1:0]      r_mem [DEPTH];
    logic [TS_W-1:0]    r_ts;
    logic [STATE_W-1:0] r_prev;
    logic               r_prev_valid;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic               r_triggered;
    logic [AW-1:0]      r_post_cnt;
    trig_fsm_t          r_fsm;

    trig_fsm_t          w_fsm_next;
    logic [AW-1:0]      w_post_cnt_next;
    logic               w_triggered_next;
    logic               w_full;
    logic               w_write;
    logic               w_read;
    logic               w_rd_adv;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_write  = i_cap_en && (r_fsm != S_FROZEN) &&
                      (i_mode || (i_state_in != r_prev) || !r_prev_valid);
    assign w_read   = o_rd_valid && i_rd_ready;
    // When full, an unread write evicts the head, so the read pointer moves either way.
    assign w_rd_adv = w_read || (w_write && w_full);

    assign o_rd_valid  = (r_count != '0);
    assign o_rd_data   = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_triggered = r_triggered;
    assign o_frozen    = (r_fsm == S_FROZEN);

    always_comb begin
        w_fsm_next       = r_fsm;
        w_post_cnt_next  = r_post_cnt;
        w_triggered_next = r_triggered;
        case (r_fsm)
            S_IDLE: begin
                if (i_trig_en)
                    w_fsm_next = S_ARMED;
            end
            S_ARMED: begin
                if (!i_trig_en) begin
                    w_fsm_next = S_IDLE;
                end else if (w_write && (i_state_in == i_trig_state)) begin
                    w_fsm_next       = S_POST;
                    w_post_cnt_next  = AW'(DEPTH / 2);
                    w_triggered_next = 1'b1;
                end
            end
            S_POST: begin
                if (w_write) begin
                    w_post_cnt_next = r_post_cnt - AW'(1);
                    if (r_post_cnt == AW'(1))
                        w_fsm_next = S_FROZEN;
                end
            end
            default: w_fsm_next = S_FROZEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
        end else if (i_clear) begin
            r_fsm       <= S_IDLE;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_post_cnt  <= w_post_cnt_next;
            r_triggered <= w_triggered_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts         <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else if (i_clear) begin
            r_ts         <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (i_cap_en) begin
                r_prev       <= i_state_in;
                r_prev_valid <= 1'b1;
            end
            if (w_write)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_adv)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_write && !w_read) begin
                if (w_full)
                    r_overflow <= 1'b1;
                else
                    r_count <= r_count + CW'(1);
            end else if (!w_write && w_read) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage is never reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (rst_n && !i_clear && w_write)
            r_mem[r_wr_ptr] <= {r_ts, i_state_in};
    end

endmodule

// File: doc/state_trace_buffer.md
# state_trace_buffer

Parametrised on-chip trace recorder for the multicycle datapath's FSM state bus. It samples a STATE_W-bit state each clock, stores timestamped entries in a DEPTH-entry circular buffer, and drains them oldest-first through a valid/ready read port. It supports change-only or every-cycle capture, overwrite-on-full with a sticky overflow flag, and a state-match trigger that freezes the buffer after a fixed post-trigger window. It sits beside the datapath, taps its State output, and serves simulation and on-board debug.

## Interface
- STATE_W, 5: width of the traced state bus.
- DEPTH, 16: number of buffer entries; power of two, ≥ 4.
- TS_W, 16: timestamp width.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of all state (same effect as reset); has priority over every other input.
- state_in  in  STATE_W  state bus being traced.
- cap_en  in  1  capture enable.
- mode  in  1  0 = record on change only, 1 = record every cycle.
- trig_en  in  1  arms the trigger.
- trig_state  in  STATE_W  trigger match value.
- rd_ready  in  1  consumer accepts the head entry.
- rd_valid  out  1  the buffer holds at least one entry.
- rd_data  out  TS_W+STATE_W  {timestamp, state} of the oldest entry; all zeros when rd_valid=0.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky; an unread entry was overwritten.
- triggered  out  1  sticky; a trigger match has been recorded.
- frozen  out  1  the post-trigger window is complete and writes are blocked.

## Operation
- **Timestamp counter:** ts increments every cycle, independent of cap_en, and wraps from 2^TS_W−1 to 0.
- **Write condition:** a write occurs when cap_en=1, frozen=0, and either mode=1, state_in≠prev, or prev_valid=0.
- **prev / prev_valid:** on every cycle with cap_en=1, prev takes state_in and prev_valid is set to 1. The first sample after reset or clear is therefore always recorded.
- **Entry contents:** each write stores {ts, state_in} at wr_ptr, then wr_ptr increments modulo DEPTH.
- **Read:** when rd_valid and rd_ready are both high, the head entry pops and rd_ptr increments modulo DEPTH. A read with rd_valid=0 is ignored.
- **Full, write without read:** the oldest entry is overwritten, rd_ptr advances, count stays at DEPTH, and overflow is set.
- **Full, write with read:** the pop and push both happen, count stays at DEPTH, and overflow is unchanged.
- **Empty, write with rd_ready high:** no bypass; the new entry is readable the next cycle.
- **Trigger states:**
  - IDLE → ARMED when trig_en=1.
  - ARMED → POST when an entry is written whose state equals trig_state. That entry counts as the trigger; triggered is set and post_cnt is loaded with DEPTH/2.
  - In POST, each further write decrements post_cnt. The write that brings it to 0 moves the FSM to FROZEN and sets frozen=1.
  - FROZEN persists until clear or reset. Reads continue normally while frozen.
  - Deasserting trig_en in ARMED returns to IDLE. Deasserting it in POST or FROZEN has no effect.
- **Reset / clear:** asynchronous reset or synchronous clear (including mid-capture or mid-POST) zeroes pointers, count, ts, prev_valid, overflow, triggered and frozen, and returns the trigger FSM to IDLE. Memory contents are not cleared.

## Timing
- **Reset values:** rd_valid=0, rd_data=0, count=0, overflow=0, triggered=0, frozen=0.
- **Write latency:** an entry sampled at edge N appears at rd_data with rd_valid=1 after edge N when the buffer was empty; count updates after edge N.
- **Read port:** rd_data reads the memory combinationally at rd_ptr. A pop at edge N presents the next entry immediately after edge N.
- **Flag timing:** triggered and frozen assert after the edge of the matching write and of the final post-trigger write, respectively. overflow asserts after the overwriting edge.
- **Throughput:** one write and one read per cycle sustained.

## Test plan
- **Change-only capture:** reset, cap_en=1, mode=0, state_in sequence 0,0,3,3,3,7 on consecutive cycles starting at ts=0 → entries {0,0},{2,3},{5,7}; count=3.
- **Every-cycle mode:** mode=1, 5 cycles of state 2 → 5 entries with consecutive timestamps. Then drain with rd_ready=1 → rd_valid low after 5 pops, rd_data=0.
- **Overflow:** DEPTH=16, mode=1, 20 writes with no reads → count=16, overflow=1, head timestamp = 5th sample's ts. Then one cycle of simultaneous read+write → count stays 16.
- **Trigger:** trig_en=1, trig_state=9, mode=1, state 9 presented at the 4th write → triggered=1 after that write; exactly 8 further writes, then frozen=1. Count stays frozen at 12 with cap_en still high.
- **Clear mid-POST and async reset:** clear asserted in POST → all flags 0, count 0, next sample recorded with ts=0 + 1 cycle. rst pulsed low mid-drain, asynchronously → outputs at reset values before the next edge.
